mux_arb_16_41: RTL and testbench

- Four-source to one-sink 16-bit collector: the return direction of the 1:4 16-bit demux tree.
- Round-robin arbitrates four valid/ready input channels onto one registered output.
- Tags each output word with the 2-bit source index, encoded exactly as the demux select (0=a, 1=b, 2=c, 3=d), so a downstream 1:4 demux can route on `out_sel` directly.
- Sits between per-lane producers and a single shared consumer (bus or memory write port).

---
 rtl/mux_arb_16_41.sv | 91 +++++++++
 tb/tb_mux_arb_16_41.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_16_41.sv
// Four-channel round-robin collector onto one registered output (return path of a 1:4 demux tree).
// Ports:
//   clk, rst       - clock; synchronous active-high reset
//   a, b, c, d     - channel 0..3 data
//   in_valid[3:0]  - per-channel valid (bit i = channel i)
//   in_ready[3:0]  - per-channel ready, combinational, at most one bit high
//   out_data       - registered output word
//   out_sel        - source index of out_data (0=a .. 3=d, same encoding as the demux select)
//   out_valid      - output register holds a word
//   out_ready      - sink accepts the word
//   xfer_cnt       - count of words accepted from the inputs, wraps
module mux_arb_16_41 #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     c,
  input  logic [W-1:0]     d,
  input  logic [3:0]       in_valid,
  output logic [3:0]       in_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int unsigned N_CH = 4;

  logic [1:0]   ptr;
  logic [1:0]   grant;
  logic         grant_vld;
  logic         can_load;
  logic         xfer;
  logic [W-1:0] grant_data;

  // Round-robin scan starting at ptr; first valid channel wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (!grant_vld && in_valid[ptr + 2'(k)]) begin
        grant     = ptr + 2'(k);
        grant_vld = 1'b1;
      end
    end
  end

  // Output register can take a new word when empty or draining this cycle.
  always_comb begin
    can_load = !out_valid || out_ready;
    xfer     = grant_vld && can_load && !rst;
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = a;
    case (grant)
      2'd0:    grant_data = a;
      2'd1:    grant_data = b;
      2'd2:    grant_data = c;
      default: grant_data = d;
    endcase
  end

  // Output register, priority pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      xfer_cnt  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant;
      ptr       <= grant + 2'd1;
      xfer_cnt  <= xfer_cnt + CNT_W'(1);
    end else if (out_ready) begin
      // Sink drained the word with nothing to replace it; data/sel keep last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_16_41.sv
module tb_mux_arb_16_41;

  logic        clk;
  logic        rst;
  logic [15:0] ch [4];
  logic [15:0] a, b, c, d;
  logic [3:0]  in_valid;
  logic        out_ready;

  logic [3:0]  in_ready, in_ready4;
  logic [15:0] out_data, out_data4;
  logic [1:0]  out_sel, out_sel4;
  logic        out_valid, out_valid4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_ptr, m_cnt, m_sel;
  bit          m_valid;
  logic [15:0] m_data;
  logic [3:0]  got_ready;

  assign a = ch[0];
  assign b = ch[1];
  assign c = ch[2];
  assign d = ch[3];

  mux_arb_16_41 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  mux_arb_16_41 #(.W(16), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational ready, advance the model, check registered outputs.
  task automatic cycle();
    logic [3:0] exp_ready;
    int g;
    bit can;
    exp_ready = '0;
    g = -1;
    can = 0;
    #3;
    if (!rst) begin
      can = !m_valid || out_ready;
      for (int k = 0; k < 4; k++)
        if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (g >= 0 && can) exp_ready[g] = 1'b1;
    end
    got_ready = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("in_ready4", 32'(in_ready4), 32'(exp_ready));
    if (rst) begin
      m_valid = 0; m_data = 16'h0; m_sel = 0; m_cnt = 0; m_ptr = 0;
    end else if (g >= 0 && can) begin
      m_valid = 1; m_data = ch[g]; m_sel = g; m_ptr = (g + 1) % 4;
      m_cnt = (m_cnt + 1) % 65536;
    end else if (out_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
    chk("xfer_cnt4", 32'(xfer_cnt4), 32'(m_cnt % 16));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  initial begin
    m_ptr = 0; m_cnt = 0; m_sel = 0; m_valid = 0; m_data = 16'h0;
    for (int i = 0; i < 4; i++) ch[i] = 16'h0;
    rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;

    // Reset then idle
    do_reset(2);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0000);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    cycle();
    chk("rst_ready_masked", 32'(got_ready), 32'd0);
    rst = 1'b0;

    // Single source on channel c
    in_valid = 4'b0100; ch[2] = 16'hBEEF; out_ready = 1'b1;
    cycle();
    chk("single_ready", 32'(got_ready), 32'b0100);
    chk("single_data", 32'(out_data), 32'hBEEF);
    chk("single_sel", 32'(out_sel), 32'd2);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_cnt", 32'(xfer_cnt), 32'd1);
    in_valid = 4'b0000;
    cycle();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_data_held", 32'(out_data), 32'hBEEF);

    // Round-robin with all channels valid
    do_reset(1);
    for (int i = 0; i < 4; i++) ch[i] = 16'(i + 1);
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_sel", 32'(out_sel), 32'(k % 4));
      chk("rr_data", 32'(out_data), 32'(k % 4 + 1));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    chk("rr_cnt", 32'(xfer_cnt), 32'd8);

    // Backpressure
    do_reset(1);
    in_valid = 4'b0001; ch[0] = 16'h1234; out_ready = 1'b1;
    cycle();
    chk("bp_load", 32'(out_data), 32'h1234);
    in_valid = 4'b0010; ch[1] = 16'h5678; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_hold_data", 32'(out_data), 32'h1234);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_ready_low", 32'(got_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_ready", 32'(got_ready), 32'b0010);
    chk("bp_next_data", 32'(out_data), 32'h5678);
    chk("bp_next_sel", 32'(out_sel), 32'd1);

    // Reset mid-stall with ptr=2
    do_reset(1);
    in_valid = 4'b0010; ch[1] = 16'hAAAA; out_ready = 1'b1;
    cycle();
    in_valid = 4'b1111; out_ready = 1'b0;
    cycle();
    chk("ms_stall_ready", 32'(got_ready), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("ms_valid", 32'(out_valid), 32'd0);
    chk("ms_cnt", 32'(xfer_cnt), 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("ms_grant0", 32'(got_ready), 32'b0001);
    chk("ms_sel0", 32'(out_sel), 32'd0);

    // Counter wrap on the 4-bit instance
    do_reset(1);
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      cycle();
      if (k == 15) chk("wrap_16", 32'(xfer_cnt4), 32'h0);
      if (k == 16) chk("wrap_17", 32'(xfer_cnt4), 32'h1);
    end
    chk("wrap_wide", 32'(xfer_cnt), 32'd17);

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom % 50) == 0;
      in_valid = 4'($urandom);
      out_ready = ($urandom % 4) != 0;
      for (int i = 0; i < 4; i++) ch[i] = 16'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
